// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: forward/inverse S-box tables,
// engine FSM states and mode encodings.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sub_bytes_seq_sbox_lane.sv
// One combinational S-box lane; mode picks the forward or inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = (mode == MODE_INV) ? INV_SBOX[din] : SBOX[din];

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed byte substitution: N_BYTES pushed through N_LANES shared
// S-box lanes, BEATS = N_BYTES/N_LANES cycles per transaction.
//
// state | meaning
// IDLE  | ready for a new transaction
// BUSY  | substituting one group of N_LANES bytes per cycle
// DONE  | full result presented, waiting for i_ready
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int N_LANES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_inv,
    input  logic [8*N_BYTES-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [8*N_BYTES-1:0] o_data,
    output logic                 o_busy
);

    localparam int BEATS = (N_LANES >= 1) ? N_BYTES / N_LANES : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (N_LANES < 1) begin : g_bad_lanes
            $error("sub_bytes_seq: N_LANES must be at least 1");
        end else if (N_BYTES % N_LANES != 0) begin : g_bad_ratio
            $error("sub_bytes_seq: N_BYTES must be a multiple of N_LANES");
        end
    endgenerate

    state_t               state, state_nxt;
    logic [CW-1:0]        beat;
    logic                 mode;
    logic [8*N_BYTES-1:0] work;
    logic [8*N_BYTES-1:0] result;
    logic [7:0]           lane_in  [N_LANES];
    logic [7:0]           lane_out [N_LANES];
    logic                 accept;
    logic                 last_beat;

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        accept    = 1'b0;
        last_beat = (beat == LAST);
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);
    assign o_data = result;

    // Beat b feeds work bytes [b*N_LANES +: N_LANES]; beat 0 is the LSB group.
    always_comb begin
        for (int l = 0; l < N_LANES; l++) begin
            lane_in[l] = work[(int'(beat) * N_LANES + l) * 8 +: 8];
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        sbox_lane u_lane (
            .mode (mode),
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            beat   <= '0;
            mode   <= MODE_FWD;
            work   <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work <= i_data;
                mode <= i_inv;
                beat <= '0;
            end else if (state == BUSY) begin
                for (int l = 0; l < N_LANES; l++) begin
                    result[(int'(beat) * N_LANES + l) * 8 +: 8] <= lane_out[l];
                end
                // Counter parks on the last beat instead of wrapping.
                if (!last_beat) beat <= beat + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq in word (4/1), full-state (16/4) and
// fully parallel (4/4) configurations.
module tb_sub_bytes_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        w_valid, w_ready_o, w_inv, w_valid_o, w_ready, w_busy;
    logic [31:0] w_data, w_out;
    logic         s_valid, s_ready_o, s_inv, s_valid_o, s_ready, s_busy;
    logic [127:0] s_data, s_out;
    logic        p_valid, p_ready_o, p_inv, p_valid_o, p_ready, p_busy;
    logic [31:0] p_data, p_out;

    int checks   = 0;
    int failures = 0;

    sub_bytes_seq #(.N_BYTES(4), .N_LANES(1)) u_w (
        .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(w_ready_o), .i_inv(w_inv),
        .i_data(w_data), .o_valid(w_valid_o), .i_ready(w_ready), .o_data(w_out), .o_busy(w_busy));

    sub_bytes_seq #(.N_BYTES(16), .N_LANES(4)) u_s (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready_o), .i_inv(s_inv),
        .i_data(s_data), .o_valid(s_valid_o), .i_ready(s_ready), .o_data(s_out), .o_busy(s_busy));

    sub_bytes_seq #(.N_BYTES(4), .N_LANES(4)) u_p (
        .i_clk(clk), .i_rst(rst), .i_valid(p_valid), .o_ready(p_ready_o), .i_inv(p_inv),
        .i_data(p_data), .o_valid(p_valid_o), .i_ready(p_ready), .o_data(p_out), .o_busy(p_busy));

    typedef struct {
        logic [31:0] data;
        logic        inv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Word engine: accept, scramble inputs while busy, optionally stall in DONE, handshake.
    task automatic run_w(input logic [31:0] d, input logic inv, input int hold,
                         output logic [31:0] got, output int lat, output logic stable);
        logic [31:0] snap;
        w_data  = d;
        w_inv   = inv;
        w_valid = 1'b1;
        w_ready = 1'b0;
        lat     = 0;
        stable  = 1'b1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            w_inv  = ~w_inv;
            w_data = $urandom;
            if (w_valid_o) break;
        end
        w_valid = 1'b0;
        got  = w_out;
        snap = w_out;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (!w_valid_o || w_ready_o || w_out !== snap) stable = 1'b0;
        end
        w_ready = 1'b1;
        @(posedge clk); #1;
        w_ready = 1'b0;
    endtask

    task automatic run_s(input logic [127:0] d, input logic inv,
                         output logic [127:0] got, output int lat);
        s_data  = d;
        s_inv   = inv;
        s_valid = 1'b1;
        lat     = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            s_valid = 1'b0;
            s_inv   = ~s_inv;
            if (s_valid_o) break;
        end
        got     = s_out;
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b0;
    endtask

    task automatic run_p(input logic [31:0] d, input logic inv,
                         output logic [31:0] got, output int lat);
        p_data  = d;
        p_inv   = inv;
        p_valid = 1'b1;
        lat     = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            p_valid = 1'b0;
            p_inv   = ~p_inv;
            if (p_valid_o) break;
        end
        got     = p_out;
        p_ready = 1'b1;
        @(posedge clk); #1;
        p_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  got;
        logic [127:0] got_s;
        logic [31:0]  got_p;
        int           lat;
        logic         stable;
        int           pulse_at [4];
        int           pulses;
        logic         tp_data_ok;

        vecs[0] = '{data: 32'hCF4F3C09, inv: 1'b0, exp: 32'h8A84EB01};
        vecs[1] = '{data: 32'h7CEDCA63, inv: 1'b1, exp: 32'h01531000};
        vecs[2] = '{data: 32'h00000000, inv: 1'b0, exp: 32'h63636363};
        vecs[3] = '{data: 32'h8A84EB01, inv: 1'b1, exp: 32'hCF4F3C09};
        vecs[4] = '{data: 32'hFFFFFFFF, inv: 1'b0, exp: 32'h16161616};
        vecs[5] = '{data: 32'h63636363, inv: 1'b1, exp: 32'h00000000};

        rst = 1'b1;
        w_valid = 1'b0; w_inv = 1'b0; w_data = '0; w_ready = 1'b0;
        s_valid = 1'b0; s_inv = 1'b0; s_data = '0; s_ready = 1'b0;
        p_valid = 1'b0; p_inv = 1'b0; p_data = '0; p_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_w_ready", 128'(w_ready_o), 128'(1'b1));
        check("rst_w_valid", 128'(w_valid_o), 128'(1'b0));
        check("rst_w_busy",  128'(w_busy),    128'(1'b0));
        check("rst_w_data",  128'(w_out),     128'(32'h0));
        check("rst_s_ready", 128'(s_ready_o), 128'(1'b1));
        check("rst_s_data",  s_out,           128'h0);
        check("rst_p_valid", 128'(p_valid_o), 128'(1'b0));

        for (int i = 0; i < 6; i++) begin
            run_w(vecs[i].data, vecs[i].inv, 0, got, lat, stable);
            check($sformatf("vec%0d_data", i), 128'(got), 128'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(5));
            check($sformatf("vec%0d_ready_after", i), 128'(w_ready_o), 128'(1'b1));
            check($sformatf("vec%0d_valid_after", i), 128'(w_valid_o), 128'(1'b0));
        end

        // Backpressure: ten stalled cycles in DONE.
        run_w(32'hCF4F3C09, 1'b0, 10, got, lat, stable);
        check("bp_data", 128'(got), 128'(32'h8A84EB01));
        check("bp_stable", 128'(stable), 128'(1'b1));
        check("bp_ready_after", 128'(w_ready_o), 128'(1'b1));

        // Reset while BUSY at beat 2.
        w_data = 32'h12345678; w_inv = 1'b0; w_valid = 1'b1;
        @(posedge clk); #1;
        w_valid = 1'b0;
        check("mid_busy", 128'(w_busy), 128'(1'b1));
        check("mid_ready", 128'(w_ready_o), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        check("mid_no_valid", 128'(w_valid_o), 128'(1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ready", 128'(w_ready_o), 128'(1'b1));
        check("rst_mid_valid", 128'(w_valid_o), 128'(1'b0));
        check("rst_mid_busy",  128'(w_busy),    128'(1'b0));
        run_w(32'h12345678, 1'b0, 0, got, lat, stable);
        check("post_rst_data", 128'(got), 128'(32'hC918B1BC));
        check("post_rst_latency", 128'(lat), 128'(5));

        // Throughput with i_valid and i_ready held high: one result per 6 cycles.
        w_data = 32'h00000000; w_inv = 1'b0; w_valid = 1'b1; w_ready = 1'b1;
        pulses = 0;
        tp_data_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (w_valid_o) begin
                if (pulses < 4) pulse_at[pulses] = c;
                pulses++;
                if (w_out !== 32'h63636363) tp_data_ok = 1'b0;
            end
        end
        w_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        w_ready = 1'b0;
        check("tp_pulses", 128'(pulses), 128'(3));
        check("tp_data", 128'(tp_data_ok), 128'(1'b1));
        if (pulses >= 2) check("tp_gap", 128'(pulse_at[1] - pulse_at[0]), 128'(6));
        else             check("tp_gap", 128'(pulses), 128'(2));

        // Full state, four lanes.
        run_s(128'h00102030405060708090A0B0C0D0E0F0, 1'b0, got_s, lat);
        check("state_fwd_data", got_s, 128'h63CAB7040953D051CD60E0E7BA70E18C);
        check("state_fwd_latency", 128'(lat), 128'(5));
        check("state_ready_after", 128'(s_ready_o), 128'(1'b1));
        run_s(128'h63CAB7040953D051CD60E0E7BA70E18C, 1'b1, got_s, lat);
        check("state_inv_data", got_s, 128'h00102030405060708090A0B0C0D0E0F0);

        // Fully parallel, single beat.
        run_p(32'h00000000, 1'b0, got_p, lat);
        check("par_fwd_data", 128'(got_p), 128'(32'h63636363));
        check("par_fwd_latency", 128'(lat), 128'(2));
        run_p(32'hFFFFFFFF, 1'b1, got_p, lat);
        check("par_inv_data", 128'(got_p), 128'(32'h7D7D7D7D));
        check("par_ready_after", 128'(p_ready_o), 128'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Parametrised, time-multiplexed byte-substitution engine. Generalises the 4-byte combinational word substitution to N_BYTES of data using N_LANES shared S-box lanes.
- Supports a per-transaction forward or inverse S-box mode.
- Sits between key-expansion/round control and the state register in both the encryption and decryption datapaths.
- Uses a valid/ready handshake on input and output, so area can be traded for latency.

Parameters:
- N_BYTES, 4, bytes per transaction (4 = word, 16 = full state); must be a multiple of N_LANES.
- N_LANES, 1, S-box lanes instantiated; BEATS = N_BYTES/N_LANES cycles per transaction.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input data valid.
- o_ready  output  1  engine can accept input.
- i_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- i_data  input  8*N_BYTES  bytes to substitute; byte k = i_data[8k+7:8k].
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  8*N_BYTES  substituted bytes, same byte order as input.
- o_busy  output  1  transaction in flight (BUSY or DONE).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_ready=1 (IDLE), o_valid=0, o_busy=0, o_data=0, beat counter=0, latched mode=0, FSM=IDLE.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid at a rising edge (accept), latch i_data into the work register and i_inv into the mode register, clear the counter, and go to BUSY.
- BUSY:
  - o_ready=0.
  - Each cycle, substitute work bytes [beat*N_LANES .. beat*N_LANES+N_LANES-1] through the lanes and write them into the result register.
  - Beat 0 processes the least-significant bytes.
  - Increment beat. At beat==BEATS-1 the last write occurs and the FSM moves to DONE.
  - Input changes during BUSY are ignored.
- DONE:
  - o_valid=1. o_data holds the full result, stable until the handshake completes.
  - When i_ready is high, go to IDLE at that edge.
  - DONE->IDLE->accept costs one IDLE cycle. No back-to-back bypass in this revision.
- Latency: accept at edge k → o_valid high from the cycle after edge k+BEATS, i.e. BEATS+1 cycles from accept to o_valid.
  - Throughput: one transaction per BEATS+2 cycles when i_ready is held high.
- Degenerate case, BEATS=1 (N_LANES=N_BYTES): BUSY lasts exactly one cycle; the same rules apply.
- Mode: a lane outputs SBOX(b) if the latched mode=0, else INV_SBOX(b). Mode never changes mid-transaction.
- Result register bytes not yet written during BUSY are don't-care. o_data is only defined while o_valid=1.
- o_busy = (state != IDLE).
- Reset mid-operation: i_rst in BUSY or DONE returns to IDLE at that edge. The transaction is dropped and o_valid drops in the same cycle. No partial result is ever flagged valid.
- i_valid held high while o_ready=0: no effect. The input is accepted only in IDLE.
- Counter width: $clog2(BEATS), minimum 1 bit. The counter never wraps beyond BEATS-1.
- Parameter check: elaboration error if N_BYTES % N_LANES != 0 or N_LANES < 1.

Decomposition:
- aes_pkg holds:
  - the 256-entry forward S-box constant and the inverse S-box constant;
  - the FSM state typedef {IDLE, BUSY, DONE};
  - the mode constants MODE_FWD=0 and MODE_INV=1.
- Sub-module sbox_lane: 8-bit combinational, selects forward or inverse table by a mode input. It is instantiated N_LANES times.
- The existing forward s_box may back the forward path inside sbox_lane.

Test Plan:
- Forward word, N_BYTES=4, N_LANES=1: i_data=0xCF4F3C09, i_inv=0 → o_data=0x8A84EB01. o_valid rises 5 cycles after accept.
- Inverse word, same configuration: i_data=0x7CEDCA63, i_inv=1 → o_data=0x01531000. i_inv toggled during BUSY has no effect.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_valid and o_data stay stable, o_ready=0. Raising i_ready completes the transaction, and o_ready=1 the next cycle.
- Full state, N_BYTES=16, N_LANES=4:
  - i_data=0x00102030405060708090A0B0C0D0E0F0 forward → 0x63CAB7040953D051CD60E0E7BA70E18C.
  - Latency is 5 cycles (BEATS=4).
- Reset mid-BUSY: assert i_rst at beat 2 → next cycle state=IDLE, o_valid=0, o_busy=0, o_ready=1. A new accept yields the correct result.
- Parallel configuration, N_LANES=N_BYTES=4: i_data=0x00000000 forward → 0x63636363, with o_valid 2 cycles after accept.
